// File: rtl/poker_types_pkg.sv
// Shared card, rank/suit and parser error types for the poker game datapath.
package poker_types;

  localparam int unsigned RANK_COUNT = 13;
  localparam int unsigned NUM_CARDS  = 52;
  localparam int unsigned IDX_W      = 6;

  typedef enum logic [3:0] {
    RANK_ACE   = 4'd0,
    RANK_TWO   = 4'd1,
    RANK_THREE = 4'd2,
    RANK_FOUR  = 4'd3,
    RANK_FIVE  = 4'd4,
    RANK_SIX   = 4'd5,
    RANK_SEVEN = 4'd6,
    RANK_EIGHT = 4'd7,
    RANK_NINE  = 4'd8,
    RANK_TEN   = 4'd9,
    RANK_JACK  = 4'd10,
    RANK_QUEEN = 4'd11,
    RANK_KING  = 4'd12
  } rank_e;

  typedef enum logic [1:0] {
    SUIT_SPADES   = 2'd0,
    SUIT_DIAMONDS = 2'd1,
    SUIT_CLUBS    = 2'd2,
    SUIT_HEARTS   = 2'd3
  } suit_e;

  typedef struct packed {
    rank_e rank;
    suit_e suit;
  } card_t;

  typedef enum logic [1:0] {
    PARSE_BAD_RANK  = 2'd0,
    PARSE_BAD_SUIT  = 2'd1,
    PARSE_TIMEOUT   = 2'd2,
    PARSE_DUPLICATE = 2'd3
  } parse_err_e;

  typedef enum logic [1:0] {
    S_RANK = 2'd0,
    S_TEN  = 2'd1,
    S_SUIT = 2'd2,
    S_HOLD = 2'd3
  } parser_state_e;

  // Position of a card in the 52-entry dealt mask: suit-major, rank-minor.
  function automatic logic [IDX_W-1:0] card_index(input card_t c);
    return IDX_W'(c.suit) * IDX_W'(RANK_COUNT) + IDX_W'(c.rank);
  endfunction

endpackage

// File: rtl/card_text_parser_decode.sv
// Combinational ASCII classifier for card text; letters are case-insensitive.
module ascii_card_decode
  import poker_types::*;
(
  input  logic [7:0] ch,
  output logic       is_rank,
  output logic       is_one,
  output logic       is_zero,
  output logic       is_suit,
  output logic       is_space,
  output rank_e      rank,
  output suit_e      suit
);

  logic [7:0] upper;

  always_comb begin
    upper = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch & 8'hDF) : ch;
  end

  // Rank and zero/one classification.
  always_comb begin
    is_rank = 1'b0;
    is_one  = 1'b0;
    is_zero = 1'b0;
    rank    = RANK_ACE;
    case (upper) inside
      8'h30:          is_zero = 1'b1;
      8'h31:          is_one  = 1'b1;
      [8'h32:8'h39]: begin
        is_rank = 1'b1;
        rank    = rank_e'(4'(upper - 8'h31));
      end
      8'h41:          begin is_rank = 1'b1; rank = RANK_ACE;   end
      8'h54:          begin is_rank = 1'b1; rank = RANK_TEN;   end
      8'h4A:          begin is_rank = 1'b1; rank = RANK_JACK;  end
      8'h51:          begin is_rank = 1'b1; rank = RANK_QUEEN; end
      8'h4B:          begin is_rank = 1'b1; rank = RANK_KING;  end
      default:        ;
    endcase
  end

  // Suit and whitespace classification.
  always_comb begin
    is_suit  = 1'b0;
    is_space = 1'b0;
    suit     = SUIT_SPADES;
    case (upper)
      8'h53:                 begin is_suit = 1'b1; suit = SUIT_SPADES;   end
      8'h44:                 begin is_suit = 1'b1; suit = SUIT_DIAMONDS; end
      8'h43:                 begin is_suit = 1'b1; suit = SUIT_CLUBS;    end
      8'h48:                 begin is_suit = 1'b1; suit = SUIT_HEARTS;   end
      8'h20, 8'h0D, 8'h0A:   is_space = 1'b1;
      default:               ;
    endcase
  end

endmodule

// File: rtl/card_text_parser.sv
// Rank+suit ASCII text to card_t parser with error reporting and partial-card timeout.
// Optional duplicate-card detection is enabled by defining CARD_DUP_CHECK_EN.
module card_text_parser
  import poker_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       card_valid,
  output card_t      card,
  input  logic       card_ready,
  output logic       parse_err,
  output parse_err_e err_code,
  output logic       in_progress,
  input  logic       clear_deck
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  parser_state_e state_q, state_d;
  card_t         card_q, card_d;
  logic          card_valid_q, card_valid_d;
  logic          parse_err_q, parse_err_d;
  parse_err_e    err_code_q, err_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic          char_ready_q, in_progress_q;
  logic          err_fire;
  parse_err_e    err_cause;
  logic          handoff;
  logic          dup_hit;
  logic          hs;

  logic  dec_is_rank, dec_is_one, dec_is_zero, dec_is_suit, dec_is_space;
  rank_e dec_rank;
  suit_e dec_suit;

  ascii_card_decode u_decode (
    .ch       (char_data),
    .is_rank  (dec_is_rank),
    .is_one   (dec_is_one),
    .is_zero  (dec_is_zero),
    .is_suit  (dec_is_suit),
    .is_space (dec_is_space),
    .rank     (dec_rank),
    .suit     (dec_suit)
  );

  assign hs = char_valid & char_ready_q;

`ifdef CARD_DUP_CHECK_EN
  logic [NUM_CARDS-1:0] mask_q, mask_d;
  card_t                cand;

  always_comb begin
    cand      = card_q;
    cand.suit = dec_suit;
    dup_hit   = mask_q[card_index(cand)];
  end

  // Clear has priority over marking the card just handed off.
  always_comb begin
    mask_d = mask_q;
    if (handoff) mask_d[card_index(card_q)] = 1'b1;
    if (clear_deck) mask_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`else
  logic unused_clear_deck;
  assign unused_clear_deck = clear_deck;
  assign dup_hit           = 1'b0;
`endif

  // Next-state, card latch, error and timeout logic.
  always_comb begin
    state_d      = state_q;
    card_d       = card_q;
    card_valid_d = card_valid_q;
    parse_err_d  = 1'b0;
    err_code_d   = err_code_q;
    cnt_d        = '0;
    cnt_inc      = cnt_q + CNT_W'(1);
    err_fire     = 1'b0;
    err_cause    = PARSE_BAD_RANK;
    handoff      = 1'b0;

    case (state_q)
      S_RANK: begin
        if (hs && !dec_is_space) begin
          if (dec_is_rank) begin
            card_d.rank = dec_rank;
            state_d     = S_SUIT;
          end else if (dec_is_one) begin
            state_d = S_TEN;
          end else begin
            err_fire = 1'b1;
          end
        end
      end
      S_TEN, S_SUIT: begin
        if (hs) begin
          if (state_q == S_TEN) begin
            if (dec_is_zero) begin
              card_d.rank = RANK_TEN;
              state_d     = S_SUIT;
            end else begin
              err_fire = 1'b1;
            end
          end else if (dec_is_suit && !dup_hit) begin
            card_d.suit  = dec_suit;
            card_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            err_fire  = 1'b1;
            err_cause = dec_is_suit ? PARSE_DUPLICATE : PARSE_BAD_SUIT;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            err_fire  = 1'b1;
            err_cause = PARSE_TIMEOUT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_HOLD: begin
        if (card_ready) begin
          handoff      = 1'b1;
          card_valid_d = 1'b0;
          state_d      = S_RANK;
        end
      end
      default: state_d = S_RANK;
    endcase

    // Any error drops the partial card and restarts at the rank.
    if (err_fire) begin
      parse_err_d = 1'b1;
      err_code_d  = err_cause;
      state_d     = S_RANK;
      card_d      = '{rank: RANK_ACE, suit: SUIT_SPADES};
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RANK;
      card_q        <= '{rank: RANK_ACE, suit: SUIT_SPADES};
      card_valid_q  <= 1'b0;
      parse_err_q   <= 1'b0;
      err_code_q    <= PARSE_BAD_RANK;
      cnt_q         <= '0;
      char_ready_q  <= 1'b1;
      in_progress_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      card_q        <= card_d;
      card_valid_q  <= card_valid_d;
      parse_err_q   <= parse_err_d;
      err_code_q    <= err_code_d;
      cnt_q         <= cnt_d;
      char_ready_q  <= (state_d != S_HOLD);
      in_progress_q <= (state_d == S_TEN) || (state_d == S_SUIT);
    end
  end

  assign char_ready  = char_ready_q;
  assign card_valid  = card_valid_q;
  assign card        = card_q;
  assign parse_err   = parse_err_q;
  assign err_code    = err_code_q;
  assign in_progress = in_progress_q;

endmodule

// File: tb/tb_card_text_parser.sv
// Scoreboard bench for card_text_parser: directed text, expected cards/errors queued, monitor compares.
module tb_card_text_parser;
  import poker_types::*;

  typedef struct {
    logic       is_err;
    card_t      card;
    parse_err_e code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       card_valid;
  card_t      card;
  logic       card_ready = 1'b1;
  logic       parse_err;
  parse_err_e err_code;
  logic       in_progress;
  logic       clear_deck = 1'b0;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  card_text_parser #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .card_valid  (card_valid),
    .card        (card),
    .card_ready  (card_ready),
    .parse_err   (parse_err),
    .err_code    (err_code),
    .in_progress (in_progress),
    .clear_deck  (clear_deck)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic card_t mk(input rank_e r, input suit_e s);
    card_t c;
    c.rank = r;
    c.suit = s;
    return c;
  endfunction

  task automatic push_card(input rank_e r, input suit_e s);
    exp_t e;
    e.is_err = 1'b0;
    e.card   = mk(r, s);
    e.code   = PARSE_BAD_RANK;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input parse_err_e c);
    exp_t e;
    e.is_err = 1'b1;
    e.card   = mk(RANK_ACE, SUIT_SPADES);
    e.code   = c;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    char_valid = 1'b1;
    char_data  = c;
    @(negedge clk);
    while (!char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("char_ready_wait", 32'(char_ready), 32'd1);
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handed-off card and every error pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (card_valid && card_ready) begin
        if (exp_q.size() == 0) check("unexpected_card", 32'(card), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("event_is_card", 32'(1'b0), 32'(e.is_err));
          if (!e.is_err) check("card", 32'(card), 32'(e.card));
        end
      end
      if (parse_err) begin
        if (exp_q.size() == 0) check("unexpected_err", 32'(err_code), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("event_is_err", 32'(1'b1), 32'(e.is_err));
          if (e.is_err) check("err_code", 32'(err_code), 32'(e.code));
        end
      end
    end
  end

  initial begin
    int lat;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_char_ready", 32'(char_ready), 32'd1);
    check("rst_card_valid", 32'(card_valid), 32'd0);
    check("rst_card", 32'(card), 32'd0);
    check("rst_parse_err", 32'(parse_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_in_progress", 32'(in_progress), 32'd0);
    rst = 1'b0;
    idle(1);

    // "Kh": card one cycle after the suit, ready dropped while holding
    push_card(RANK_KING, SUIT_HEARTS);
    send_char(8'h4B);
    check("k_in_progress", 32'(in_progress), 32'd1);
    send_char(8'h68);
    check("kh_latency_valid", 32'(card_valid), 32'd1);
    check("kh_char_ready_low", 32'(char_ready), 32'd0);
    check("kh_in_progress", 32'(in_progress), 32'd0);
    idle(1);
    check("kh_valid_drop", 32'(card_valid), 32'd0);
    check("kh_ready_back", 32'(char_ready), 32'd1);

    // " 10S" held against back-pressure for 5 cycles
    card_ready = 1'b0;
    push_card(RANK_TEN, SUIT_SPADES);
    send_char(8'h20);
    check("space_ignored", 32'(in_progress), 32'd0);
    send_char(8'h31);
    send_char(8'h30);
    send_char(8'h53);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(card_valid), 32'd1);
      check("hold_card", 32'(card), 32'(mk(RANK_TEN, SUIT_SPADES)));
      check("hold_char_ready", 32'(char_ready), 32'd0);
    end
    @(posedge clk);
    #1 card_ready = 1'b1;
    idle(2);
    check("ts_idle_valid", 32'(card_valid), 32'd0);
    check("ts_idle_ready", 32'(char_ready), 32'd1);

    // "15" is a bad rank, error pulse lasts one cycle; then "AC"
    push_err(PARSE_BAD_RANK);
    send_char(8'h31);
    send_char(8'h35);
    check("bad_ten_pulse", 32'(parse_err), 32'd1);
    check("bad_ten_code", 32'(err_code), 32'(PARSE_BAD_RANK));
    idle(1);
    check("bad_ten_one_cycle", 32'(parse_err), 32'd0);
    push_card(RANK_ACE, SUIT_CLUBS);
    send_char(8'h41);
    send_char(8'h43);
    idle(2);

    // "X" bad rank; "Q " whitespace in suit position; "9d" lowercase suit
    push_err(PARSE_BAD_RANK);
    send_char(8'h58);
    push_err(PARSE_BAD_SUIT);
    send_char(8'h51);
    send_char(8'h20);
    push_card(RANK_NINE, SUIT_DIAMONDS);
    send_char(8'h39);
    send_char(8'h64);
    idle(2);

    // Timeout: "Q" then idle fires 8 cycles after the handshake edge
    push_err(PARSE_TIMEOUT);
    send_char(8'h51);
    check("to_in_progress", 32'(in_progress), 32'd1);
    lat = 0;
    while (!parse_err && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("to_latency", 32'(lat), 32'd8);
    check("to_in_progress_clr", 32'(in_progress), 32'd0);
    push_err(PARSE_BAD_RANK);
    send_char(8'h44);
    idle(2);

    // Duplicate detection and clear_deck
    push_card(RANK_SEVEN, SUIT_DIAMONDS);
    send_char(8'h37);
    send_char(8'h44);
    idle(2);
`ifdef CARD_DUP_CHECK_EN
    push_err(PARSE_DUPLICATE);
`else
    push_card(RANK_SEVEN, SUIT_DIAMONDS);
`endif
    send_char(8'h37);
    send_char(8'h44);
    idle(2);
    clear_deck = 1'b1;
    idle(1);
    clear_deck = 1'b0;
    push_card(RANK_SEVEN, SUIT_DIAMONDS);
    send_char(8'h37);
    send_char(8'h44);
    idle(2);

    // Reset mid-card drops "J" silently; then "JS"
    send_char(8'h4A);
    check("j_in_progress", 32'(in_progress), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(card_valid), 32'd0);
    check("mid_rst_card", 32'(card), 32'd0);
    check("mid_rst_err", 32'(parse_err), 32'd0);
    check("mid_rst_in_progress", 32'(in_progress), 32'd0);
    check("mid_rst_ready", 32'(char_ready), 32'd1);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("post_rst_err", 32'(parse_err), 32'd0);
    push_card(RANK_JACK, SUIT_SPADES);
    send_char(8'h4A);
    send_char(8'h53);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
